// File: rtl/i3c2_result_bank.sv
// I2C result bank: 32x8 result registers with valid bits, registered read port
// and a show-ahead change-event FIFO for a streaming consumer.
module i3c2_result_bank #(
  parameter int FIFO_AW     = 3,
  parameter bit CHANGE_ONLY = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [4:0]         reg_addr,
  input  logic [7:0]         reg_data,
  input  logic               reg_write,
  input  logic               clear,
  input  logic [4:0]         rd_addr,
  output logic [7:0]         rd_data,
  output logic               rd_valid,
  output logic [31:0]        valid_mask,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [4:0]         evt_addr,
  output logic [7:0]         evt_data,
  output logic [FIFO_AW:0]   evt_level,
  output logic               evt_overflow
);

  localparam int DEPTH = 2 ** FIFO_AW;

  logic [7:0]         mem_q  [32];
  logic [4:0]         fa_q   [DEPTH];
  logic [7:0]         fd_q   [DEPTH];

  logic [31:0]        valid_q, valid_d;
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   level_q, level_d;
  logic               evt_valid_q, evt_valid_d;
  logic               ovf_q, ovf_d;
  logic [7:0]         rd_data_q, rd_data_d;
  logic               rd_valid_q, rd_valid_d;

  logic full, pop, push, push_acc, bypass;

  // Push/pop decisions; change detection uses pre-write contents, and a
  // same-cycle clear makes the entry look invalid so the write always pushes.
  always_comb begin
    full     = level_q[FIFO_AW];
    pop      = evt_valid_q && evt_ready;
    push     = reg_write && (!CHANGE_ONLY || clear ||
               !valid_q[reg_addr] || (mem_q[reg_addr] != reg_data));
    push_acc = push && (!full || pop);
    bypass   = reg_write && (reg_addr == rd_addr);
  end

  // Next-state for valid bits, overflow flag, FIFO pointers and read port.
  always_comb begin
    valid_d = clear ? '0 : valid_q;
    if (reg_write) valid_d[reg_addr] = 1'b1;

    ovf_d = clear ? 1'b0 : ovf_q;
    if (push && full && !pop) ovf_d = 1'b1;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_acc) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
    if (pop)      rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
    if (push_acc && !pop)      level_d = level_q + (FIFO_AW+1)'(1);
    else if (!push_acc && pop) level_d = level_q - (FIFO_AW+1)'(1);
    evt_valid_d = (level_d != '0);

    rd_data_d  = bypass ? reg_data : mem_q[rd_addr];
    rd_valid_d = bypass || valid_q[rd_addr];
  end

  // Control and output registers; reset wins over every other action.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      evt_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      evt_valid_q <= evt_valid_d;
      ovf_q       <= ovf_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  // Storage arrays are never cleared; writes are suppressed during reset.
  always_ff @(posedge clk) begin
    if (!rst && reg_write) mem_q[reg_addr] <= reg_data;
    if (!rst && push_acc) begin
      fa_q[wr_ptr_q] <= reg_addr;
      fd_q[wr_ptr_q] <= reg_data;
    end
  end

  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign valid_mask   = valid_q;
  assign evt_valid    = evt_valid_q;
  assign evt_addr     = evt_valid_q ? fa_q[rd_ptr_q] : '0;
  assign evt_data     = evt_valid_q ? fd_q[rd_ptr_q] : '0;
  assign evt_level    = level_q;
  assign evt_overflow = ovf_q;

endmodule

// File: tb/tb_i3c2_result_bank.sv
// Testbench for i3c2_result_bank: directed scenarios plus a randomized run
// against a queue-based behavioural model.
module tb_i3c2_result_bank;

  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst, reg_write, clear, evt_ready;
  logic [4:0]  reg_addr, rd_addr;
  logic [7:0]  reg_data;
  logic [7:0]  rd_data;
  logic        rd_valid, evt_valid, evt_overflow;
  logic [31:0] valid_mask;
  logic [4:0]  evt_addr;
  logic [7:0]  evt_data;
  logic [AW:0] evt_level;

  int n_vec = 0;
  int n_err = 0;

  // behavioural model state
  logic [7:0]  m_mem   [32];
  bit          m_known [32];
  bit   [31:0] m_valid;
  logic [12:0] m_q [$];
  bit          m_ovf;
  logic [7:0]  m_rd;
  bit          m_rdv;
  bit          m_rd_known;

  i3c2_result_bank #(.FIFO_AW(AW), .CHANGE_ONLY(1'b1)) dut (
    .clk(clk), .rst(rst), .reg_addr(reg_addr), .reg_data(reg_data),
    .reg_write(reg_write), .clear(clear), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .valid_mask(valid_mask),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_addr(evt_addr),
    .evt_data(evt_data), .evt_level(evt_level),
    .evt_overflow(evt_overflow)
  );

  always #5 clk = ~clk;

  // One clock edge; the model applies the spec rules to the inputs seen there.
  task automatic tick();
    bit pop, push;
    @(posedge clk);
    if (rst) begin
      m_valid = '0;
      m_q.delete();
      m_ovf = 0;
      m_rd = 8'h00;
      m_rdv = 0;
      m_rd_known = 1;
    end else begin
      if (reg_write && reg_addr == rd_addr) begin
        m_rd = reg_data; m_rdv = 1; m_rd_known = 1;
      end else begin
        m_rd = m_mem[rd_addr]; m_rdv = m_valid[rd_addr];
        m_rd_known = m_known[rd_addr];
      end
      pop  = (m_q.size() != 0) && evt_ready;
      push = reg_write && (clear || !m_valid[reg_addr] ||
             m_mem[reg_addr] != reg_data);
      if (pop) void'(m_q.pop_front());
      if (clear) begin m_valid = '0; m_ovf = 0; end
      if (push) begin
        if (m_q.size() < DEPTH) m_q.push_back({reg_addr, reg_data});
        else m_ovf = 1;
      end
      if (reg_write) begin
        m_mem[reg_addr] = reg_data;
        m_known[reg_addr] = 1;
        m_valid[reg_addr] = 1;
      end
    end
    #1;
  endtask

  task automatic idle();
    rst = 0; reg_write = 0; clear = 0; evt_ready = 0;
    reg_addr = 0; reg_data = 0; rd_addr = 0;
  endtask

  task automatic do_reset();
    idle(); rst = 1; tick(); rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if ({rd_data, rd_valid, valid_mask, evt_valid, evt_addr, evt_data,
         evt_level, evt_overflow} !== '0) begin
      n_err++;
      $display("FAIL reset: outputs rd=%h rv=%b mask=%h ev=%b ea=%h ed=%h lvl=%0d ovf=%b, required all 0",
               rd_data, rd_valid, valid_mask, evt_valid, evt_addr, evt_data,
               evt_level, evt_overflow);
    end
  endtask

  task automatic test_basic_write();
    do_reset();
    reg_write = 1; reg_addr = 3; reg_data = 8'hA5; rd_addr = 3;
    tick();
    reg_write = 0;
    tick();
    n_vec++;
    if (rd_data !== 8'hA5 || rd_valid !== 1'b1) begin
      n_err++;
      $display("FAIL basic_read: got %h/%b, required a5/1", rd_data, rd_valid);
    end
    n_vec++;
    if (valid_mask !== 32'h8) begin
      n_err++;
      $display("FAIL basic_mask: got %h, required 00000008", valid_mask);
    end
    n_vec++;
    if (evt_valid !== 1'b1 || evt_addr !== 5'd3 || evt_data !== 8'hA5 ||
        evt_level !== 4'd1) begin
      n_err++;
      $display("FAIL basic_evt: got v=%b a=%0d d=%h l=%0d, required 1/3/a5/1",
               evt_valid, evt_addr, evt_data, evt_level);
    end
  endtask

  task automatic test_hold();
    logic [12:0] exp [2];
    exp[0] = {5'd7, 8'h12};
    exp[1] = {5'd7, 8'h13};
    do_reset();
    reg_write = 1; reg_addr = 7; reg_data = 8'h12;
    repeat (10) tick();
    reg_data = 8'h13;
    tick();
    reg_write = 0;
    n_vec++;
    if (evt_level !== 4'd2) begin
      n_err++;
      $display("FAIL hold_level: got %0d, required 2", evt_level);
    end
    evt_ready = 1;
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if (evt_valid !== 1'b1 || {evt_addr, evt_data} !== exp[i]) begin
        n_err++;
        $display("FAIL hold_evt%0d: got %b %0d/%h, required 1 %0d/%h", i,
                 evt_valid, evt_addr, evt_data, exp[i][12:8], exp[i][7:0]);
      end
      tick();
    end
    n_vec++;
    if (evt_valid !== 1'b0) begin
      n_err++;
      $display("FAIL hold_empty: evt_valid=%b, required 0", evt_valid);
    end
    evt_ready = 0;
  endtask

  task automatic test_overflow();
    do_reset();
    reg_write = 1; reg_addr = 0;
    for (int i = 0; i < 9; i++) begin
      reg_data = 8'h40 + 8'(i);
      tick();
    end
    reg_write = 0;
    n_vec++;
    if (evt_level !== 4'd8 || evt_overflow !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_full: level=%0d ovf=%b, required 8/1",
               evt_level, evt_overflow);
    end
    evt_ready = 1;
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if (evt_valid !== 1'b1 || evt_addr !== 5'd0 ||
          evt_data !== 8'h40 + 8'(i)) begin
        n_err++;
        $display("FAIL ovf_drain%0d: got %b %0d/%h, required 1 0/%h", i,
                 evt_valid, evt_addr, evt_data, 8'h40 + 8'(i));
      end
      tick();
    end
    evt_ready = 0;
    n_vec++;
    if (evt_level !== 4'd0 || evt_valid !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_drained: level=%0d valid=%b, required 0/0",
               evt_level, evt_valid);
    end
    clear = 1;
    tick();
    clear = 0;
    n_vec++;
    if (evt_overflow !== 1'b0 || valid_mask !== 32'h0) begin
      n_err++;
      $display("FAIL ovf_clear: ovf=%b mask=%h, required 0/00000000",
               evt_overflow, valid_mask);
    end
  endtask

  task automatic test_full_pushpop();
    do_reset();
    reg_write = 1; reg_addr = 1;
    for (int i = 0; i < 8; i++) begin
      reg_data = 8'h80 + 8'(i);
      tick();
    end
    reg_data = 8'hEE; evt_ready = 1;
    tick();
    reg_write = 0;
    n_vec++;
    if (evt_level !== 4'd8 || evt_overflow !== 1'b0) begin
      n_err++;
      $display("FAIL full_pp: level=%0d ovf=%b, required 8/0",
               evt_level, evt_overflow);
    end
    for (int i = 1; i < 9; i++) begin
      logic [7:0] e;
      e = (i == 8) ? 8'hEE : 8'h80 + 8'(i);
      n_vec++;
      if (evt_valid !== 1'b1 || evt_data !== e) begin
        n_err++;
        $display("FAIL full_pp_drain%0d: got %b/%h, required 1/%h", i,
                 evt_valid, evt_data, e);
      end
      tick();
    end
    evt_ready = 0;
  endtask

  task automatic test_bypass_clear();
    do_reset();
    reg_write = 1; reg_addr = 5; reg_data = 8'h3C; rd_addr = 5;
    tick();
    reg_write = 0;
    n_vec++;
    if (rd_data !== 8'h3C || rd_valid !== 1'b1) begin
      n_err++;
      $display("FAIL bypass: got %h/%b, required 3c/1", rd_data, rd_valid);
    end
    clear = 1; reg_write = 1; reg_addr = 2; reg_data = 8'h77;
    tick();
    clear = 0; reg_write = 0;
    n_vec++;
    if (valid_mask !== 32'h4) begin
      n_err++;
      $display("FAIL clear_write_mask: got %h, required 00000004", valid_mask);
    end
    n_vec++;
    if (evt_level !== 4'd2) begin
      n_err++;
      $display("FAIL clear_write_push: level=%0d, required 2", evt_level);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    reg_write = 1;
    for (int i = 0; i < 4; i++) begin
      reg_addr = 5'(9 + i); reg_data = 8'h11;
      tick();
    end
    rst = 1; reg_addr = 9; reg_data = 8'h22; evt_ready = 1; clear = 1;
    tick();
    rst = 0; reg_write = 0; evt_ready = 0; clear = 0;
    n_vec++;
    if (evt_valid !== 1'b0 || evt_level !== 4'd0 || valid_mask !== 32'h0) begin
      n_err++;
      $display("FAIL rst_mid: v=%b l=%0d mask=%h, required 0/0/00000000",
               evt_valid, evt_level, valid_mask);
    end
    rd_addr = 9;
    tick();
    n_vec++;
    if (rd_data !== 8'h11 || rd_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_nowrite: got %h/%b, required 11/0",
               rd_data, rd_valid);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      rst       = ($urandom_range(0, 299) == 0);
      clear     = ($urandom_range(0, 39) == 0);
      reg_write = ($urandom_range(0, 9) < 7);
      reg_addr  = 5'($urandom_range(0, 7));
      reg_data  = 8'($urandom_range(0, 3));
      evt_ready = ($urandom_range(0, 2) == 0);
      rd_addr   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                              : 5'($urandom_range(0, 7));
      tick();
      n_vec++;
      if (evt_level !== 4'(m_q.size()) || evt_valid !== (m_q.size() != 0)) begin
        n_err++;
        $display("FAIL rnd_level c=%0d: got %0d/%b, required %0d/%b", c,
                 evt_level, evt_valid, m_q.size(), m_q.size() != 0);
      end
      n_vec++;
      if (m_q.size() != 0 && {evt_addr, evt_data} !== m_q[0]) begin
        n_err++;
        $display("FAIL rnd_head c=%0d: got %0d/%h, required %0d/%h", c,
                 evt_addr, evt_data, m_q[0][12:8], m_q[0][7:0]);
      end
      n_vec++;
      if (valid_mask !== m_valid || evt_overflow !== m_ovf) begin
        n_err++;
        $display("FAIL rnd_mask c=%0d: got %h/%b, required %h/%b", c,
                 valid_mask, evt_overflow, m_valid, m_ovf);
      end
      n_vec++;
      if (rd_valid !== m_rdv || (m_rd_known && rd_data !== m_rd)) begin
        n_err++;
        $display("FAIL rnd_read c=%0d: got %h/%b, required %h/%b", c,
                 rd_data, rd_valid, m_rd, m_rdv);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      m_mem[i] = 8'h00;
      m_known[i] = 0;
    end
    m_valid = '0; m_ovf = 0; m_rd = 0; m_rdv = 0; m_rd_known = 1;
    idle();
    test_reset();
    test_basic_write();
    test_hold();
    test_overflow();
    test_full_pushpop();
    test_bypass_clear();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/i3c2_result_bank.md
Name: i3c2_result_bank

Overview:
- Downstream consumer of the I2C sequencer's register-write port (5-bit address, 8-bit data, write strobe).
- Stores every byte read from the I2C bus into a 32x8 result register file and tracks per-entry valid bits.
- Queues change events in a FIFO for a streaming consumer using a valid/ready handshake.
- Fabric logic reads results randomly through a registered read port.

Parameters:
- FIFO_AW, 3, log2 of event FIFO depth; depth = 2**FIFO_AW, default 8 entries.
- CHANGE_ONLY, 1, 1 = enqueue an event only when an entry's value changes or the entry becomes valid; 0 = enqueue on every write cycle.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous active-high reset.
- reg_addr  in  5  write address from the sequencer.
- reg_data  in  8  write data from the sequencer.
- reg_write  in  1  write strobe; every cycle it is high is one write.
- clear  in  1  synchronous clear of valid bits and the overflow flag.
- rd_addr  in  5  random-read address.
- rd_data  out  8  registered read data.
- rd_valid  out  1  registered valid bit of the entry at rd_addr.
- valid_mask  out  32  per-entry valid bits.
- evt_valid  out  1  FIFO head holds an event.
- evt_ready  in  1  consumer accepts the head event.
- evt_addr  out  5  head event address.
- evt_data  out  8  head event data.
- evt_level  out  FIFO_AW+1  current FIFO occupancy.
- evt_overflow  out  1  sticky: an event was dropped because the FIFO was full.

Behaviour:
- Reset: registers are not cleared, but all valid bits are 0. Outputs: rd_data=0, rd_valid=0, valid_mask=0, evt_valid=0, evt_addr=0, evt_data=0, evt_level=0, evt_overflow=0. FIFO pointers are set to 0.
- Write (reg_write=1): mem[reg_addr] <= reg_data and valid[reg_addr] <= 1 at the next edge.
- Push condition:
  - CHANGE_ONLY=1: push when valid[reg_addr]=0 or mem[reg_addr]!=reg_data, comparing against the pre-write contents.
  - CHANGE_ONLY=0: push on every write cycle.
  - A strobe held high with constant data therefore produces exactly one event when CHANGE_ONLY=1.
- Read port:
  - Latency 1 cycle: rd_data/rd_valid at edge N+1 reflect rd_addr at edge N.
  - Write-first: if reg_write=1 and reg_addr==rd_addr in the same cycle, rd_data returns reg_data and rd_valid returns 1.
- clear:
  - Zeroes all valid bits and evt_overflow.
  - Does not flush the FIFO and does not alter mem.
  - If clear and reg_write occur in the same cycle, valid[reg_addr] ends at 1, all other valid bits end at 0, and the push is evaluated as if the entry were invalid, so it always pushes.
- FIFO:
  - Show-ahead: evt_addr/evt_data are the head entry whenever evt_valid=1.
  - Head outputs stay stable while evt_valid=1 and evt_ready=0.
  - Pop when evt_valid and evt_ready; the next entry appears the following cycle.
  - evt_valid = (level != 0), registered with the level.
- Full FIFO:
  - A push while level==depth with no simultaneous pop is dropped and sets evt_overflow=1 at the next edge; mem and valid are still updated.
  - A push and a pop in the same cycle when full are both accepted, and the level stays at depth.
  - A push and a pop in the same cycle when the FIFO is empty: the push is accepted and the pop is ignored (evt_valid=0), so the level becomes 1.
- Pointers wrap modulo depth. Level counts 0..depth with width FIFO_AW+1.
- Reset mid-operation: rst has priority over write, clear and pop in the same cycle. Any queued events are discarded.
- evt_ready is ignored while evt_valid=0.

Test Plan:
- Reset, then write addr 3 = 0xA5 for 1 cycle; read addr 3 -> rd_data=0xA5 and rd_valid=1 one cycle later; valid_mask=0x00000008; evt_valid=1, evt_addr=3, evt_data=0xA5, evt_level=1.
- With CHANGE_ONLY=1, hold reg_write high for 10 cycles with addr 7 = 0x12, then 1 cycle of 0x13 -> exactly 2 events: (7,0x12) then (7,0x13).
- With evt_ready=0, perform 9 writes of distinct data to addr 0 -> evt_level=8 and evt_overflow=1; draining yields the first 8 values in order. Then pulse clear -> evt_overflow=0 and valid_mask=0.
- With the FIFO full, assert a write and evt_ready in the same cycle -> level stays 8, evt_overflow stays 0, and the new event emerges last.
- Same cycle: write addr 5 = 0x3C with rd_addr=5 -> next cycle rd_data=0x3C and rd_valid=1 (bypass). Same cycle: clear with a write to addr 2 -> valid_mask=0x00000004.
- Assert rst with 4 events queued and a write pending -> evt_valid=0, evt_level=0 and valid_mask=0 next cycle; the write is not performed.
